// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: memory bus types and the
// status word layout that software and the transmitter side agree on.
package uart_rx_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic        mem_error;
    logic [31:0] mem_rdata;
  } mem_out_type;

  localparam int RX_EMPTY = 8;
  localparam int RX_FERR  = 9;
  localparam int RX_OVR   = 10;

  // Assemble the read-back status word; unused bits stay zero.
  function automatic logic [31:0] rx_status(input logic [7:0] data,
                                            input logic       empty,
                                            input logic       ferr,
                                            input logic       ovr);
    logic [31:0] s;
    s           = '0;
    s[7:0]      = data;
    s[RX_EMPTY] = empty;
    s[RX_FERR]  = ferr;
    s[RX_OVR]   = ovr;
    return s;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO with extra-MSB pointers. The head is read
// combinationally so a bus request can return it in the same cycle it pops.
module uart_fifo #(
  parameter int width = 8,
  parameter int depth = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] wdata,
  input  logic             pop,
  output logic [width-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = (depth > 1) ? $clog2(depth) : 1;

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [width-1:0] r_mem [depth];
  logic             w_do_push;
  logic             w_do_pop;

  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);

  // A pop frees a slot in the same cycle, so push-while-full still succeeds then.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  assign rdata = r_mem[r_rptr[AW-1:0]];

  // Pointer update; wrap-around is plain modulo arithmetic on AW+1 bits.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      if (w_do_pop)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx, deframes bytes with a mid-bit
// sampling FSM, buffers them in a FIFO and serves status/data reads.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int clock_rate = 868,
  parameter int depth      = 16
) (
  input  logic        reset,
  input  logic        clock,
  input  mem_in_type  uart_in,
  output mem_out_type uart_out,
  input  logic        rx
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  typedef struct packed {
    state_t      state;
    logic [31:0] counter;
    logic [2:0]  index;
    logic [7:0]  shift;
    logic        frame_err;
    logic        overrun;
  } reg_t;

  localparam logic [31:0] HALF = 32'(clock_rate / 2);
  localparam logic [31:0] FULL = 32'(clock_rate);

  reg_t        r;
  reg_t        rin;
  logic        r_rx1;
  logic        r_rx_s;
  logic        r_ready;
  logic [31:0] r_rdata;

  logic        w_read;
  logic        w_push;
  logic        w_pop;
  logic        w_frame_set;
  logic        w_ovr_set;
  logic        w_empty;
  logic        w_full;
  logic [7:0]  w_head;
  logic [31:0] w_status;
  logic        w_unused_wdata;

  assign w_read         = uart_in.mem_valid && (uart_in.mem_wstrb == 4'b0000);
  assign w_pop          = w_read && !w_empty;
  assign w_status       = rx_status(w_empty ? 8'h00 : w_head, w_empty, r.frame_err, r.overrun);
  assign w_unused_wdata = ^uart_in.mem_wdata;

  uart_fifo #(
    .width(8),
    .depth(depth)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .push (w_push),
    .wdata(r.shift),
    .pop  (w_pop),
    .rdata(w_head),
    .empty(w_empty),
    .full (w_full)
  );

  // Two-flop synchronizer for the asynchronous rx pin; idles high.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rx1  <= 1'b1;
      r_rx_s <= 1'b1;
    end else begin
      r_rx1  <= rx;
      r_rx_s <= r_rx1;
    end
  end

  // Next-state logic: deframing FSM, push decisions and sticky flag updates.
  always_comb begin
    rin         = r;
    w_push      = 1'b0;
    w_frame_set = 1'b0;
    w_ovr_set   = 1'b0;
    case (r.state)
      IDLE: begin
        rin.counter = '0;
        if (!r_rx_s) rin.state = START;
      end
      START: begin
        if (r.counter == HALF) begin
          rin.counter = '0;
          if (!r_rx_s) begin
            rin.index = '0;
            rin.state = DATA;
          end else begin
            rin.state = IDLE;
          end
        end else begin
          rin.counter = r.counter + 32'd1;
        end
      end
      DATA: begin
        if (r.counter == FULL) begin
          rin.shift   = {r_rx_s, r.shift[7:1]};
          rin.counter = '0;
          rin.index   = r.index + 3'd1;
          if (r.index == 3'd7) rin.state = STOP;
        end else begin
          rin.counter = r.counter + 32'd1;
        end
      end
      STOP: begin
        if (r.counter == FULL) begin
          rin.counter = '0;
          rin.state   = IDLE;
          if (r_rx_s) w_push      = 1'b1;
          else        w_frame_set = 1'b1;
        end else begin
          rin.counter = r.counter + 32'd1;
        end
      end
      default: rin.state = IDLE;
    endcase
    w_ovr_set     = w_push && w_full && !w_pop;
    rin.frame_err = (r.frame_err && !w_read) || w_frame_set;
    rin.overrun   = (r.overrun && !w_read) || w_ovr_set;
  end

  // Receiver state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r.state     <= IDLE;
      r.counter   <= '0;
      r.index     <= '0;
      r.shift     <= '0;
      r.frame_err <= 1'b0;
      r.overrun   <= 1'b0;
    end else begin
      r <= rin;
    end
  end

  // Registered bus response: one-cycle ready, status word only for reads.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= uart_in.mem_valid;
      r_rdata <= w_read ? w_status : 32'd0;
    end
  end

  assign uart_out.mem_ready = r_ready;
  assign uart_out.mem_error = 1'b0;
  assign uart_out.mem_rdata = r_rdata;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that consumes the 8N1 line format produced by the team's UART transmitter: 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1), idle high.
- Samples the asynchronous rx pin and deframes bytes into a small receive FIFO.
- Exposes the FIFO to the core over the standard memory request/response interface, placed alongside the transmitter in the peripheral region.

Parameters:
- clock_rate, default 868: bit period is clock_rate+1 clock cycles, identical to the transmitter's bit timing.
- depth, default 16: receive FIFO entries; power of two, minimum 2.

Ports:
- reset  input  1  synchronous, active-low reset.
- clock  input  1  clock.
- uart_in  input  mem_in_type  request; fields used: mem_valid, mem_wstrb, mem_wdata.
- uart_out  output  mem_out_type  response; fields used: mem_rdata, mem_error, mem_ready.
- rx  input  1  asynchronous serial input, idle high.

Behaviour:
- Reset (reset==0 at a clock edge):
  - FSM to IDLE, counter 0, FIFO empty, sticky flags cleared.
  - Synchronizer flops set to 1.
  - uart_out.mem_ready=0, mem_rdata=0, mem_error=0.
  - A frame in progress is abandoned; nothing is pushed.
- Input sync: rx passes through two flops; the FSM sees only rx_s, so the pin-to-FSM delay is 2 cycles.
- Timing: 32-bit counter; half = clock_rate/2 (integer); full = clock_rate.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: counter=0. When rx_s==0, go to START.
  - START: when counter==half, sample rx_s. If 0: counter=0, bit index=0, go to DATA. If 1 (glitch): go to IDLE, nothing pushed.
  - DATA: when counter==full, sample rx_s into shift[7] and shift right; counter=0; index+1. After the 8th sample go to STOP.
  - STOP: when counter==full, sample rx_s.
    - If 1: push the byte.
    - If 0: discard the byte and set sticky frame_err.
    - In both cases go to IDLE. This happens at mid-stop-bit, so a start bit immediately following is still caught.
- Push timing: the byte is visible in the FIFO the cycle after the stop sample.
- FIFO:
  - Pointers are log2(depth)+1 bits; wrap-around is natural modulo arithmetic.
  - empty when the pointers are equal; full when the low bits are equal and the MSBs differ.
  - Push while full (and no pop that cycle): byte dropped, sticky overrun set, FIFO contents unchanged.
  - Push and pop in the same cycle: both take effect, even when full; count is unchanged.
- Bus reads (mem_valid==1, |mem_wstrb==0):
  - Registered response: mem_ready=1 exactly one cycle after the request, otherwise 0. Requests on consecutive cycles are each answered.
  - mem_rdata[7:0] = head byte, or 0 if empty.
  - mem_rdata[8] = empty (1 = no data).
  - mem_rdata[9] = frame_err; mem_rdata[10] = overrun; all other bits 0.
  - A read when not empty pops the head.
  - Every read clears frame_err and overrun. A flag set in the same cycle as the read remains set.
- Bus writes (|mem_wstrb!=0): no state change; mem_ready=1 next cycle, mem_error=0, mem_rdata=0.
- mem_error is always 0.

Decomposition:
- Shared package (wires): status bit positions RX_EMPTY=8, RX_FERR=9, RX_OVR=10, so software and the transmitter side share the same definitions.
- Local: FSM state enum and the register struct (state, counter, index, shift, flags), in the same r/rin/v style as the transmitter.
- One natural sub-module: uart_fifo (parameters width, depth; ports push, wdata, pop, rdata, empty, full). It is reusable later for a TX buffer.

Test Plan (clock_rate=15, i.e. 16 cycles/bit; depth=4):
- Drive byte 0x55 in 8N1 on rx, then read → rdata=0x055, mem_ready one cycle after the read. Next read → rdata=0x100 (empty).
- Connect the uart_tx tx output to rx with the same clock_rate. Write 0xA3 then 0x0F to the transmitter, then read twice → 0x0A3, 0x00F in order.
- Drive a 6-cycle low glitch on rx, then idle → no push; read returns 0x100.
- Drive a frame 0x3C with stop bit 0, then read → 0x300 (empty + frame_err). Second read → 0x100 (flag cleared).
- Send 5 bytes 0x01..0x05 with no reads, then 5 reads → 0x401 (overrun), 0x002, 0x003, 0x004, then 0x100.
- Assert reset in the middle of a DATA bit of 0xFF, then release with rx high → FIFO empty, read 0x100; the next full frame 0x81 is received correctly.
